// File: rtl/ibex_multdiv_issue.sv
// rtl/ibex_multdiv_issue.sv - issue/response sequencer in front of the slow multiplier/divider
//
// Purpose:
//   Accepts one MUL/MULH/DIV/REM request per req handshake and registers its
//   operands. It keeps the multdiv enable/select/operand inputs stable for the
//   whole operation, captures the result, and returns it on a rsp handshake
//   together with the number of RUN cycles spent (saturating at 2^CntW-1).
//   flush_i aborts an in-flight operation or drops a pending response.
//
// Optional feature:
//   IBEX_MULTDIV_RESULT_CACHE_EN - a single-entry result cache. An accept whose
//   {operator, signed_mode, op_a, op_b} matches the last captured result goes
//   straight to RESP with rsp_cycles_o = 0. The cache is bypassed while
//   data_ind_timing_i is set. Only reset invalidates it.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    request handshake
//   req_operator_i             0 MULL, 1 MULH, 2 DIV, 3 REM
//   req_signed_mode_i          bit0 op_a signed, bit1 op_b signed
//   req_op_a_i, req_op_b_i     operands
//   flush_i                    abort in-flight operation / pending response
//   data_ind_timing_i          data-independent timing (disables cache hits)
//   md_mult_en_o, md_div_en_o  multdiv dynamic enables
//   md_mult_sel_o, md_div_sel_o multdiv static selects
//   md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o  registered operation
//   md_valid_i, md_result_i    multdiv result
//   md_ready_o                 result consumed (multdiv_ready_id)
//   rsp_valid_o/rsp_ready_i    response handshake
//   rsp_result_o               result
//   rsp_cycles_o               RUN cycles spent, 0 on cache hit

module ibex_multdiv_issue #(
  parameter int unsigned CntW = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_operator_i,
  input  logic [1:0]      req_signed_mode_i,
  input  logic [31:0]     req_op_a_i,
  input  logic [31:0]     req_op_b_i,

  input  logic            flush_i,
  input  logic            data_ind_timing_i,

  output logic            md_mult_en_o,
  output logic            md_div_en_o,
  output logic            md_mult_sel_o,
  output logic            md_div_sel_o,
  output logic [1:0]      md_operator_o,
  output logic [1:0]      md_signed_mode_o,
  output logic [31:0]     md_op_a_o,
  output logic [31:0]     md_op_b_o,
  input  logic            md_valid_i,
  input  logic [31:0]     md_result_i,
  output logic            md_ready_o,

  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [31:0]     rsp_result_o,
  output logic [CntW-1:0] rsp_cycles_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  state_e          state_q, state_d;
  logic [1:0]      op_q;
  logic [1:0]      sm_q;
  logic [31:0]     op_a_q;
  logic [31:0]     op_b_q;
  logic [31:0]     result_q;
  logic [CntW-1:0] cnt_q;

  logic            accept;
  logic            capture;
  logic            md_active;
  logic            is_mult;
  logic            cache_hit;
  logic [31:0]     cache_result;

  // Requests are only taken in IDLE; a flush in the same cycle blocks the accept.
  assign accept    = (state_q == S_IDLE) && req_valid_i && !flush_i;
  // A RUN result is kept only when no flush arrives with it.
  assign capture   = (state_q == S_RUN) && md_valid_i && !flush_i;
  // DRAIN keeps the multdiv driven so it can finish and return to its IDLE.
  assign md_active = (state_q == S_RUN) || (state_q == S_DRAIN);
  // MULL/MULH have operator bit1 clear, DIV/REM have it set.
  assign is_mult   = !op_q[1];

`ifdef IBEX_MULTDIV_RESULT_CACHE_EN
  logic        cache_valid_q;
  logic [1:0]  cache_op_q;
  logic [1:0]  cache_sm_q;
  logic [31:0] cache_a_q;
  logic [31:0] cache_b_q;
  logic [31:0] cache_res_q;

  assign cache_hit = cache_valid_q && !data_ind_timing_i &&
                     (cache_op_q == req_operator_i) &&
                     (cache_sm_q == req_signed_mode_i) &&
                     (cache_a_q  == req_op_a_i) &&
                     (cache_b_q  == req_op_b_i);
  assign cache_result = cache_res_q;

  // Filled from the registered operation on every kept RUN capture; flushes
  // never invalidate the entry since the stored result is still correct.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cache_valid_q <= 1'b0;
      cache_op_q    <= 2'd0;
      cache_sm_q    <= 2'd0;
      cache_a_q     <= 32'd0;
      cache_b_q     <= 32'd0;
      cache_res_q   <= 32'd0;
    end else if (capture) begin
      cache_valid_q <= 1'b1;
      cache_op_q    <= op_q;
      cache_sm_q    <= sm_q;
      cache_a_q     <= op_a_q;
      cache_b_q     <= op_b_q;
      cache_res_q   <= md_result_i;
    end
  end
`else
  logic unused_data_ind_timing;
  assign unused_data_ind_timing = data_ind_timing_i;
  assign cache_hit    = 1'b0;
  assign cache_result = 32'd0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = cache_hit ? S_RESP : S_RUN;
      end
      S_RUN: begin
        if (md_valid_i)   state_d = flush_i ? S_IDLE : S_RESP;
        else if (flush_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (md_valid_i) state_d = S_IDLE;
      end
      S_RESP: begin
        if (rsp_ready_i || flush_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= 2'd0;
      sm_q     <= 2'd0;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      result_q <= 32'd0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= req_operator_i;
        sm_q   <= req_signed_mode_i;
        op_a_q <= req_op_a_i;
        op_b_q <= req_op_b_i;
        cnt_q  <= '0;
        if (cache_hit) result_q <= cache_result;
      end
      if (state_q == S_RUN) begin
        if (cnt_q != CntMax) cnt_q <= cnt_q + CntOne;
        if (capture) result_q <= md_result_i;
      end
    end
  end

  assign req_ready_o      = (state_q == S_IDLE) && !flush_i;

  assign md_mult_en_o     = md_active && is_mult;
  assign md_mult_sel_o    = md_active && is_mult;
  assign md_div_en_o      = md_active && !is_mult;
  assign md_div_sel_o     = md_active && !is_mult;
  assign md_ready_o       = md_active;

  assign md_operator_o    = op_q;
  assign md_signed_mode_o = sm_q;
  assign md_op_a_o        = op_a_q;
  assign md_op_b_o        = op_b_q;

  assign rsp_valid_o      = (state_q == S_RESP);
  assign rsp_result_o     = result_q;
  assign rsp_cycles_o     = cnt_q;

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// tb/tb_ibex_multdiv_issue.sv - directed self-checking bench for ibex_multdiv_issue

module tb_ibex_multdiv_issue;

  localparam int CntW = 6;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [1:0]      req_operator_i = 2'd0;
  logic [1:0]      req_signed_mode_i = 2'd0;
  logic [31:0]     req_op_a_i = 32'd0;
  logic [31:0]     req_op_b_i = 32'd0;
  logic            flush_i = 1'b0;
  logic            data_ind_timing_i = 1'b0;
  logic            md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
  logic [1:0]      md_operator_o, md_signed_mode_o;
  logic [31:0]     md_op_a_o, md_op_b_o;
  logic            md_valid_i = 1'b0;
  logic [31:0]     md_result_i = 32'd0;
  logic            md_ready_o;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b1;
  logic [31:0]     rsp_result_o;
  logic [CntW-1:0] rsp_cycles_o;

  int n_cmp = 0;
  int n_err = 0;
  int md_lat = 0;
  int md_cnt = 0;

  ibex_multdiv_issue #(.CntW(CntW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operator_i(req_operator_i), .req_signed_mode_i(req_signed_mode_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
    .flush_i(flush_i), .data_ind_timing_i(data_ind_timing_i),
    .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
    .md_mult_sel_o(md_mult_sel_o), .md_div_sel_o(md_div_sel_o),
    .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
    .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o),
    .md_valid_i(md_valid_i), .md_result_i(md_result_i), .md_ready_o(md_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_cycles_o(rsp_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference multiplier/divider with RISC-V M semantics.
  function automatic logic [31:0] md_model(input logic [1:0] op, input logic [1:0] sm,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, prod;
    ea = {(sm[0] ? {32{a[31]}} : 32'd0), a};
    eb = {(sm[1] ? {32{b[31]}} : 32'd0), b};
    prod = ea * eb;
    case (op)
      2'd0: return prod[31:0];
      2'd1: return prod[63:32];
      2'd2: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (sm[0]) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
          return $signed(a) / $signed(b);
        end
        return a / b;
      end
      default: begin
        if (b == 32'd0) return a;
        if (sm[0]) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
          return $signed(a) % $signed(b);
        end
        return a % b;
      end
    endcase
  endfunction

  // Multdiv stand-in: result valid after md_lat extra enabled cycles.
  always @(negedge clk_i) begin
    if (md_mult_en_o || md_div_en_o) begin
      if (md_cnt >= md_lat) begin
        md_valid_i  = 1'b1;
        md_result_i = md_model(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
        md_cnt      = 0;
      end else begin
        md_valid_i = 1'b0;
        md_cnt++;
      end
    end else begin
      md_valid_i = 1'b0;
      md_cnt     = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a request and returns one step after the accepting edge.
  task automatic do_req(input logic [1:0] op, input logic [1:0] sm,
                        input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    req_operator_i = op; req_signed_mode_i = sm;
    req_op_a_i = a; req_op_b_i = b; req_valid_i = 1'b1;
    #1;
    while (!req_ready_o && n < 50) begin
      tick();
      n++;
    end
    chk("accept_bound", 32'(n < 50), 32'd1);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid_o && lat < 200) begin
      tick();
      lat++;
    end
    chk("rsp_timeout", 32'(rsp_valid_o), 32'd1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [1:0] sm,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int cyc);
    int l;
    rsp_ready_i = 1'b1;
    do_req(op, sm, a, b);
    wait_rsp(l);
    res = rsp_result_o;
    cyc = int'(rsp_cycles_o);
    tick();
    chk("rsp_single", 32'(rsp_valid_o), 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    int cyc, lat;

    // Reset
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_en", {md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_ready_o}, 32'd0);
    chk("rst_ops", md_op_a_o | md_op_b_o | {28'd0, md_operator_o, md_signed_mode_o}, 32'd0);
    chk("rst_rsp", rsp_result_o | {26'd0, rsp_cycles_o}, 32'd0);
    rst_ni = 1'b1;
    tick();

    // 1: MULL 7*6, result in the third RUN cycle
    md_lat = 2;
    rsp_ready_i = 1'b1;
    do_req(2'd0, 2'b00, 32'd7, 32'd6);
    chk("t1_run_ready", 32'(req_ready_o), 32'd0);
    chk("t1_mult_en", {md_mult_en_o, md_mult_sel_o, md_div_en_o, md_div_sel_o, md_ready_o}, 32'b11001);
    wait_rsp(lat);
    chk("t1_lat", lat, 32'd3);
    chk("t1_result", rsp_result_o, 32'd42);
    chk("t1_cycles", {26'd0, rsp_cycles_o}, 32'd3);
    chk("t1_resp_ready", 32'(req_ready_o), 32'd0);
    chk("t1_resp_en", {md_mult_en_o, md_div_en_o}, 32'd0);
    tick();
    chk("t1_after_valid", 32'(rsp_valid_o), 32'd0);
    chk("t1_after_ready", 32'(req_ready_o), 32'd1);

    // Minimum latency: result valid in first RUN cycle
    md_lat = 0;
    do_req(2'd0, 2'b00, 32'd11, 32'd13);
    chk("min_run_valid", 32'(rsp_valid_o), 32'd0);
    wait_rsp(lat);
    chk("min_lat", lat, 32'd1);
    chk("min_result", rsp_result_o, 32'd143);
    chk("min_cycles", {26'd0, rsp_cycles_o}, 32'd1);
    tick();

    // 2: division corner cases
    run_op(2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, res, cyc);
    chk("t2_div_ovf", res, 32'h8000_0000);
    run_op(2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, res, cyc);
    chk("t2_rem_ovf", res, 32'd0);
    run_op(2'd2, 2'b11, 32'd1234, 32'd0, res, cyc);
    chk("t2_div_zero", res, 32'hFFFF_FFFF);
    run_op(2'd3, 2'b11, 32'd5, 32'd0, res, cyc);
    chk("t2_rem_zero", res, 32'd5);

    // 3: MULH unsigned with response back-pressure; a new request waits
    md_lat = 3;
    rsp_ready_i = 1'b0;
    do_req(2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rsp(lat);
    req_operator_i = 2'd0; req_signed_mode_i = 2'b00;
    req_op_a_i = 32'd1; req_op_b_i = 32'd1; req_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", 32'(rsp_valid_o), 32'd1);
      chk("t3_hold_result", rsp_result_o, 32'hFFFF_FFFE);
      chk("t3_hold_cycles", {26'd0, rsp_cycles_o}, 32'd4);
      chk("t3_no_accept", 32'(req_ready_o), 32'd0);
      chk("t3_op_a_reg", md_op_a_o, 32'hFFFF_FFFF);
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    chk("t3_hs_done", 32'(rsp_valid_o), 32'd0);
    chk("t3_ready_next", 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    chk("t3_next_op", md_op_a_o, 32'd1);
    wait_rsp(lat);
    chk("t3_next_result", rsp_result_o, 32'd1);
    tick();

    // 4: flush three cycles into a DIV, drain until md_valid
    md_lat = 8;
    do_req(2'd2, 2'b00, 32'd100, 32'd7);
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    chk("t4_drain_en", {md_div_en_o, md_div_sel_o, md_ready_o, md_mult_en_o}, 32'b1110);
    chk("t4_drain_ready", 32'(req_ready_o), 32'd0);
    lat = 0;
    while (md_div_en_o && lat < 50) begin
      chk("t4_no_rsp", 32'(rsp_valid_o), 32'd0);
      tick();
      lat++;
    end
    chk("t4_drain_len", lat, 32'd6);
    chk("t4_idle_ready", 32'(req_ready_o), 32'd1);
    chk("t4_idle_rsp", 32'(rsp_valid_o), 32'd0);
    md_lat = 1;
    run_op(2'd0, 2'b00, 32'd3, 32'd3, res, cyc);
    chk("t4_mull", res, 32'd9);

    // 5: flush blocks an accept in IDLE; flush drops a pending response
    req_operator_i = 2'd0; req_op_a_i = 32'd2; req_op_b_i = 32'd3;
    req_valid_i = 1'b1; flush_i = 1'b1;
    #1;
    chk("t5_flush_ready", 32'(req_ready_o), 32'd0);
    tick();
    req_valid_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("t5_not_accepted", {md_mult_en_o, md_div_en_o, rsp_valid_o, req_ready_o}, 32'b0001);
    rsp_ready_i = 1'b0;
    do_req(2'd0, 2'b00, 32'd2, 32'd3);
    wait_rsp(lat);
    chk("t5_result", rsp_result_o, 32'd6);
    flush_i = 1'b1;
    #1;
    chk("t5_flush_valid", 32'(rsp_valid_o), 32'd1);
    tick();
    flush_i = 1'b0;
    #1;
    chk("t5_dropped", 32'(rsp_valid_o), 32'd0);
    chk("t5_idle", 32'(req_ready_o), 32'd1);
    rsp_ready_i = 1'b1;

    // 6: repeated DIV 100/7
    md_lat = 4;
    run_op(2'd2, 2'b00, 32'd100, 32'd7, res, cyc);
    chk("t6_first", res, 32'd14);
    chk("t6_first_cyc", cyc, 32'd5);
`ifdef IBEX_MULTDIV_RESULT_CACHE_EN
    do_req(2'd2, 2'b00, 32'd100, 32'd7);
    chk("t6_hit_valid", 32'(rsp_valid_o), 32'd1);
    chk("t6_hit_result", rsp_result_o, 32'd14);
    chk("t6_hit_cycles", {26'd0, rsp_cycles_o}, 32'd0);
    tick();
    data_ind_timing_i = 1'b1;
    run_op(2'd2, 2'b00, 32'd100, 32'd7, res, cyc);
    data_ind_timing_i = 1'b0;
    chk("t6_dit_result", res, 32'd14);
    chk("t6_dit_cycles", cyc, 32'd5);
`else
    run_op(2'd2, 2'b00, 32'd100, 32'd7, res, cyc);
    chk("t6_repeat_result", res, 32'd14);
    chk("t6_repeat_cycles", cyc, 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
